// File: rtl/countdown_pkg.sv
// -----------------------------------------------------------------------------
// countdown_pkg
// Shared definitions for the countdown timer block.
//   - state_e       : 2-bit FSM state encoding (IDLE, ARMED, RUN, DONE)
//   - DEFAULT_WIDTH : default count / load value width
//   - DEFAULT_PRE_W : default prescale field width
//   - is_running()  : helper that decodes the RUN state
// -----------------------------------------------------------------------------
package countdown_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_PRE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic is_running(input state_e s);
    return (s == ST_RUN);
  endfunction

endpackage : countdown_pkg

// File: rtl/countdown_prescaler.sv
// -----------------------------------------------------------------------------
// countdown_prescaler
// Programmable divider: while en is high the internal counter advances once
// per cycle and tick is asserted on the cycle where it equals div, at which
// point it wraps to 0. With en low the counter holds its phase, so a paused
// countdown resumes exactly where it left off.
//
// Ports
//   clk   in   1      clock, rising edge
//   rst_n in   1      asynchronous active-low reset
//   en    in   1      advance the divider this cycle
//   clr   in   1      force the divider back to 0 (wins over en)
//   div   in   PRE_W  terminal value; tick period is div+1 enabled cycles
//   tick  out  1      high on the enabled cycle that completes a period
// -----------------------------------------------------------------------------
module countdown_prescaler
  import countdown_pkg::*;
#(
  parameter int PRE_W = DEFAULT_PRE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [PRE_W-1:0] div,
  output logic             tick
);

  logic [PRE_W-1:0] cnt_q;
  logic [PRE_W-1:0] cnt_d;

  // Combinational so the parent can act on the same edge the divider wraps.
  assign tick = en && (cnt_q == div);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : (cnt_q + PRE_W'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : countdown_prescaler

// File: rtl/countdown_8b.sv
// -----------------------------------------------------------------------------
// countdown_8b
// Loadable, pausable countdown timer with a programmable prescaler.
// load captures load_val into count and the reload register and arms the
// timer; start runs it; stop pauses it without losing count or prescaler
// phase. When count steps from 1 to 0 a one-cycle expire pulse is produced.
//
// Build option
//   COUNTDOWN_AUTO_RELOAD_EN : when defined, expiry reloads count from the
//                              reload register and keeps running (a reload
//                              value of 0 still ends in DONE). When undefined
//                              the timer stops in DONE with count held at 0.
//
// Ports
//   clk      in   1      clock, rising edge
//   rst_n    in   1      asynchronous active-low reset
//   load     in   1      capture load_val (highest priority, any state)
//   load_val in   WIDTH  initial / reload value
//   start    in   1      start or resume (ignored in IDLE and RUN)
//   stop     in   1      pause (only acts in RUN)
//   prescale in   PRE_W  divider, sampled only when start is accepted
//   count    out  WIDTH  remaining value (registered)
//   busy     out  1      high while in RUN
//   expire   out  1      registered one-cycle pulse on reaching 0
// -----------------------------------------------------------------------------
module countdown_8b
  import countdown_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int PRE_W = DEFAULT_PRE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic [PRE_W-1:0] prescale,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             expire
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state_q,      state_d;
  logic [WIDTH-1:0] count_q,      count_d;
  logic [WIDTH-1:0] reload_q,     reload_d;
  logic [PRE_W-1:0] prescale_r_q, prescale_r_d;
  logic             expire_q,     expire_d;

  logic             pre_en;
  logic             pre_clr;
  logic             pre_tick;

  // The divider only advances on genuine RUN cycles: a load or stop on the
  // same edge freezes it (load then clears it).
  assign pre_en  = is_running(state_q) && !load && !stop;
  assign pre_clr = load;

  countdown_prescaler #(
    .PRE_W (PRE_W)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pre_en),
    .clr   (pre_clr),
    .div   (prescale_r_q),
    .tick  (pre_tick)
  );

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      reload_q     <= '0;
      prescale_r_q <= '0;
      expire_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      reload_q     <= reload_d;
      prescale_r_q <= prescale_r_d;
      expire_q     <= expire_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Priority is load > stop > start.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    reload_d     = reload_q;
    prescale_r_d = prescale_r_q;
    expire_d     = 1'b0;

    if (load) begin
      // Also swallows any expiry that would have happened on this edge.
      state_d  = ST_ARMED;
      count_d  = load_val;
      reload_d = load_val;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Nothing to count until a value has been loaded.
        end

        ST_ARMED, ST_DONE: begin
          if (start) begin
            if (count_q == '0) begin
              // Nothing left to count: signal expiry without entering RUN.
              state_d  = ST_DONE;
              expire_d = 1'b1;
            end else begin
              state_d      = ST_RUN;
              prescale_r_d = prescale;
            end
          end
        end

        ST_RUN: begin
          if (stop) begin
            state_d = ST_ARMED;
          end else if (pre_tick) begin
            if (count_q == ONE) begin
              expire_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
              // Divider has just wrapped to 0, so the next period is full.
              if (reload_q != '0) begin
                count_d = reload_q;
              end else begin
                count_d = '0;
                state_d = ST_DONE;
              end
`else
              count_d = '0;
              state_d = ST_DONE;
`endif
            end else begin
              count_d = count_q - ONE;
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

`ifndef COUNTDOWN_AUTO_RELOAD_EN
  // Without auto-reload the stored value never feeds the count path.
  logic unused_reload;
  assign unused_reload = ^reload_q;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    count  = count_q;
    busy   = is_running(state_q);
    expire = expire_q;
  end

  // RUN is only ever entered or kept with a non-zero count.
  assert property (@(posedge clk) disable iff (!rst_n) busy |-> (count != '0));

endmodule : countdown_8b
